// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding, the fixed
// IFU access size and the RAM base address used by the bench.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_LS = 2'b10,
    GAP     = 2'b11
  } state_t;

  localparam logic [2:0]  SIZE_D   = 3'b011;
  localparam logic [63:0] RAM_BASE = 64'h8000_0000;

endpackage

// File: rtl/mem_arb_prio.sv
// Arbitration decision between IFU and LSU.
// LSU normally wins; after STARVE_MAX consecutive LSU grants with the IFU
// waiting, the IFU is forced on the next decision.
// Ports:
//   clock, reset        : clock, async active-high reset
//   arb_en              : a grant may be issued this cycle (FSM idle)
//   if_valid, lsu_valid : requests
//   grant_if, grant_ls  : combinational one-hot grant (zero when !arb_en)
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en,
  input  logic if_valid,
  input  logic lsu_valid,
  output logic grant_if,
  output logic grant_ls
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          forced;

  assign forced   = (starve_cnt == CW'(STARVE_MAX)) && if_valid;
  assign grant_ls = arb_en && lsu_valid && !forced;
  assign grant_if = arb_en && if_valid && !grant_ls;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls) begin
      if (!if_valid)
        starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM read/write port between the IFU and the LSU.
// Registered grants, LSU priority with IFU anti-starvation, per-transaction
// timeout watchdog and a one-cycle guard (GAP) between transactions.
// Ports:
//   clock, reset          : clock, async active-high reset
//   if_*                  : IFU request (valid/addr) and completion (ready/rdata)
//   lsu_*                 : LSU request (valid/wen/addr/wdata/size) and completion
//   ram_rw_*              : RAM port (cen/wen/addr/wdata/size out, ready/data in)
//   bus_err_o             : one-cycle pulse when a transaction times out
//
// state   | meaning
// IDLE    | no transaction; arbitrate and latch the winner
// BUSY_IF | IFU read in flight, cen asserted
// BUSY_LS | LSU access in flight, cen asserted
// GAP     | guard cycle, swallows a trailing RAM ready
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              lsu_valid_i,
  input  logic              lsu_wen_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic [2:0]        lsu_size_i,
  output logic              lsu_ready_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              ram_rw_cen_o,
  output logic              ram_rw_wen_o,
  output logic [ADDR_W-1:0] ram_rw_addr_o,
  output logic [DATA_W-1:0] ram_rw_wdata_o,
  output logic [2:0]        ram_rw_size_o,
  input  logic              ram_rw_ready_i,
  input  logic [DATA_W-1:0] ram_rw_data_i,
  output logic              bus_err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        size_q;
  logic              wen_q;
  logic [TW-1:0]     tcnt;
  logic              arb_en, grant_if, grant_ls;
  logic              busy, done, timeout_hit;

  assign arb_en = (state == IDLE);

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clock     (clock),
    .reset     (reset),
    .arb_en    (arb_en),
    .if_valid  (if_valid_i),
    .lsu_valid (lsu_valid_i),
    .grant_if  (grant_if),
    .grant_ls  (grant_ls)
  );

  assign busy        = (state == BUSY_IF) || (state == BUSY_LS);
  // A real ready in the abort cycle wins over the timeout.
  assign timeout_hit = busy && !ram_rw_ready_i && (tcnt == TW'(TIMEOUT - 1));
  assign done        = busy && (ram_rw_ready_i || timeout_hit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_ls)      state_nx = BUSY_LS;
        else if (grant_if) state_nx = BUSY_IF;
      end
      BUSY_IF, BUSY_LS: if (done) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
    end else if (grant_ls) begin
      addr_q  <= lsu_addr_i;
      wdata_q <= lsu_wdata_i;
      size_q  <= lsu_size_i;
      wen_q   <= lsu_wen_i;
    end else if (grant_if) begin
      addr_q  <= if_addr_i;
      wdata_q <= '0;
      size_q  <= SIZE_D;
      wen_q   <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              tcnt <= '0;
    else if (busy && !done) tcnt <= tcnt + 1'b1;
    else                    tcnt <= '0;
  end

  always_comb begin
    ram_rw_cen_o   = busy;
    ram_rw_wen_o   = busy && wen_q;
    ram_rw_addr_o  = addr_q;
    ram_rw_wdata_o = wdata_q;
    ram_rw_size_o  = size_q;
    if_ready_o     = (state == BUSY_IF) && done;
    lsu_ready_o    = (state == BUSY_LS) && done;
    if_rdata_o     = '0;
    lsu_rdata_o    = '0;
    if ((state == BUSY_IF) && ram_rw_ready_i) if_rdata_o  = ram_rw_data_i;
    if ((state == BUSY_LS) && ram_rw_ready_i) lsu_rdata_o = ram_rw_data_i;
    bus_err_o      = timeout_hit;
  end

endmodule
